// File: rtl/subleq_pkg.sv
// Shared subleq types and constants used by the core, host bridge and memory arbiter.
package subleq_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    typedef enum logic {
        PRI_CPU  = 1'b0,
        PRI_HOST = 1'b1
    } pri_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } owner_tag_t;

    function automatic logic is_read(input logic gnt, input logic we);
        return gnt & ~we;
    endfunction

endpackage

// File: rtl/subleq_starve_ctr.sv
// Saturating host wait counter; the priority state flips to host once the count hits MAX_WAIT.
module subleq_starve_ctr
    import subleq_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic iClock,
    input  logic iReset,
    input  logic iInc,
    input  logic iClr,
    output logic oAtMax
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    pri_e             pri_q, pri_d;

    always_comb begin
        cnt_d = cnt_q;
        if (iClr) begin
            cnt_d = '0;
        end else if (iInc && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Host priority is held until the host is served or withdraws.
    always_comb begin
        pri_d = pri_q;
        case (pri_q)
            PRI_CPU:  if (cnt_d == MaxCnt) pri_d = PRI_HOST;
            PRI_HOST: if (iClr) pri_d = PRI_CPU;
            default:  pri_d = PRI_CPU;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            cnt_q <= '0;
            pri_q <= PRI_CPU;
        end else begin
            cnt_q <= cnt_d;
            pri_q <= pri_d;
        end
    end

    assign oAtMax = (pri_q == PRI_HOST);

endmodule

// File: rtl/subleq_mem_arbiter.sv
// Single-port memory arbiter between the subleq CPU sequencer and the host port.
module subleq_mem_arbiter
    import subleq_pkg::*;
#(
    parameter int unsigned ADDR_W   = subleq_pkg::ADDR_W,
    parameter int unsigned DATA_W   = subleq_pkg::DATA_W,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              iClock,
    input  logic              iReset,

    input  logic              iCpuReq,
    input  logic              iCpuWe,
    input  logic [31:0]       iCpuAddr,
    input  logic [DATA_W-1:0] iCpuData,
    output logic              oCpuGnt,
    output logic              oCpuValid,
    output logic [DATA_W-1:0] oCpuQ,

    input  logic              iHostReq,
    input  logic              iHostWe,
    input  logic [31:0]       iHostAddr,
    input  logic [DATA_W-1:0] iHostData,
    output logic              oHostGnt,
    output logic              oHostValid,
    output logic [DATA_W-1:0] oHostQ,

    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemData,
    output logic              oMemWren,
    input  logic [DATA_W-1:0] iMemQ
);

    logic       host_pri;
    logic       cpu_gnt, host_gnt;
    logic       host_wait;
    owner_tag_t tag_q, tag_d;

    // Upper address bits alias onto the memory and are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iCpuAddr[31:ADDR_W], iHostAddr[31:ADDR_W]};

    subleq_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .iClock (iClock),
        .iReset (iReset),
        .iInc   (host_wait),
        .iClr   (~host_wait),
        .oAtMax (host_pri)
    );

    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (!iReset) begin
            if (host_pri && iHostReq) begin
                host_gnt = 1'b1;
            end else if (iCpuReq) begin
                cpu_gnt = 1'b1;
            end else if (iHostReq) begin
                host_gnt = 1'b1;
            end
        end
    end

    assign host_wait = iHostReq & ~host_gnt;

    always_comb begin
        oMemAddr = iCpuAddr[ADDR_W-1:0];
        oMemData = iCpuData;
        oMemWren = cpu_gnt & iCpuWe;
        if (host_gnt) begin
            oMemAddr = iHostAddr[ADDR_W-1:0];
            oMemData = iHostData;
            oMemWren = iHostWe;
        end
    end

    always_comb begin
        tag_d.valid = is_read(cpu_gnt, iCpuWe) | is_read(host_gnt, iHostWe);
        tag_d.owner = host_gnt ? OWN_HOST : OWN_CPU;
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    // Gating by reset also kills a read granted in the cycle just before reset.
    assign oCpuValid  = tag_q.valid & (tag_q.owner == OWN_CPU) & ~iReset;
    assign oHostValid = tag_q.valid & (tag_q.owner == OWN_HOST) & ~iReset;
    assign oCpuQ      = iMemQ;
    assign oHostQ     = iMemQ;
    assign oCpuGnt    = cpu_gnt;
    assign oHostGnt   = host_gnt;

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// Vector-table bench for subleq_mem_arbiter with a read-return scoreboard and memory model.
module tb_subleq_mem_arbiter;

    typedef struct {
        string       name;
        logic        rst;
        logic        creq;
        logic        cwe;
        logic [31:0] caddr;
        logic [31:0] cdata;
        logic        hreq;
        logic        hwe;
        logic [31:0] haddr;
        logic [31:0] hdata;
        logic        ecg;
        logic        ehg;
    } vec_t;

    typedef struct {
        logic        host;
        logic [31:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        creq, cwe, hreq, hwe;
    logic [31:0] caddr, cdata, haddr, hdata;
    logic        cgnt, cvalid, hgnt, hvalid;
    logic [31:0] cq, hq;
    logic [12:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    logic [31:0] ram [0:8191];
    logic [12:0] ram_addr_q;
    logic [31:0] shadow [0:8191];

    vec_t tbl[$];
    sb_t  sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    subleq_mem_arbiter dut (
        .iClock     (clk),
        .iReset     (rst),
        .iCpuReq    (creq),
        .iCpuWe     (cwe),
        .iCpuAddr   (caddr),
        .iCpuData   (cdata),
        .oCpuGnt    (cgnt),
        .oCpuValid  (cvalid),
        .oCpuQ      (cq),
        .iHostReq   (hreq),
        .iHostWe    (hwe),
        .iHostAddr  (haddr),
        .iHostData  (hdata),
        .oHostGnt   (hgnt),
        .oHostValid (hvalid),
        .oHostQ     (hq),
        .oMemAddr   (mem_addr),
        .oMemData   (mem_data),
        .oMemWren   (mem_wren),
        .iMemQ      (mem_q)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 'h10) return 32'h0000_0007;
        return 32'hA500_0000 ^ (i * 32'h9E37);
    endfunction

    // Registered-address RAM: controls captured mid-cycle, applied on the rising edge.
    assign mem_q = ram[ram_addr_q];
    initial begin
        logic        w;
        logic [12:0] a;
        logic [31:0] d;
        for (int i = 0; i < 8192; i++) ram[i] = init_word(i);
        ram_addr_q = '0;
        forever begin
            @(negedge clk);
            w = mem_wren;
            a = mem_addr;
            d = mem_data;
            @(posedge clk);
            if (w) ram[a] = d;
            ram_addr_q = a;
        end
    end

    function automatic vec_t mk(input string nm, input logic r,
                                input logic cr, input logic cw, input logic [31:0] ca,
                                input logic [31:0] cd, input logic hr, input logic hw,
                                input logic [31:0] ha, input logic [31:0] hd,
                                input logic eg_c, input logic eg_h);
        vec_t v;
        v.name = nm;   v.rst = r;
        v.creq = cr;   v.cwe = cw;   v.caddr = ca; v.cdata = cd;
        v.hreq = hr;   v.hwe = hw;   v.haddr = ha; v.hdata = hd;
        v.ecg  = eg_c; v.ehg = eg_h;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    initial begin
        logic        exp_cv, exp_hv, exp_wren;
        logic [31:0] exp_q, exp_addr;
        sb_t         e;
        logic [1:0]  drop_pat [0:7];

        rst = 1'b1;
        creq = 0; cwe = 0; caddr = 0; cdata = 0;
        hreq = 0; hwe = 0; haddr = 0; hdata = 0;
        for (int i = 0; i < 8192; i++) shadow[i] = init_word(i);

        tbl.push_back(mk("rst0", 1, 1, 1, 'h10, 'h1, 1, 1, 'h11, 'h2, 0, 0));
        tbl.push_back(mk("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("cpu_rd10", 0, 1, 0, 'h10, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("idle_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("host_wr3fff", 0, 0, 0, 0, 0, 1, 1, 'h3FFF, 'hDEAD_BEEF, 0, 1));
        tbl.push_back(mk("cpu_rd1fff", 0, 1, 0, 'h1FFF, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("cpu_wr30", 0, 1, 1, 'h30, 'h1234_5678, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("cpu_rd30", 0, 1, 0, 'h30, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("cpu_rd20", 0, 1, 0, 'h20, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("host_rd21", 0, 0, 0, 0, 0, 1, 0, 'h21, 0, 0, 1));
        tbl.push_back(mk("idle_b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk($sformatf("contend%0d", i), 0, 1, 0, 'h40 + i, 0,
                             1, 0, 'h50, 0, i != 4, i == 4));
        tbl.push_back(mk("idle_c", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drop_pat = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk($sformatf("drop%0d", i), 0, 1, 0, 'h60 + i, 0,
                             drop_pat[i][0], 0, 'h70, 0, !drop_pat[i][1], drop_pat[i][1]));
        tbl.push_back(mk("idle_d", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("host_solo", 0, 0, 0, 0, 0, 1, 0, 'h2010, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk($sformatf("pre_rst%0d", i), 0, 1, 0, 'h80 + i, 0,
                             1, 0, 'h50, 0, 1, 0));
        tbl.push_back(mk("rd_before_rst", 0, 1, 0, 'h10, 0, 1, 0, 'h50, 0, 1, 0));
        tbl.push_back(mk("mid_rst0", 1, 1, 1, 'h10, 'h5, 1, 1, 'h50, 'h6, 0, 0));
        tbl.push_back(mk("mid_rst1", 1, 1, 0, 'h10, 0, 1, 0, 'h50, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk($sformatf("post_rst%0d", i), 0, 1, 0, 'h90 + i, 0,
                             1, 0, 'h51, 0, i != 4, i == 4));
        tbl.push_back(mk("idle_e", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk);
            #1;
            rst  = tbl[k].rst;
            creq = tbl[k].creq; cwe = tbl[k].cwe; caddr = tbl[k].caddr; cdata = tbl[k].cdata;
            hreq = tbl[k].hreq; hwe = tbl[k].hwe; haddr = tbl[k].haddr; hdata = tbl[k].hdata;
            @(negedge clk);

            exp_cv = 1'b0;
            exp_hv = 1'b0;
            exp_q  = '0;
            if (tbl[k].rst) begin
                sb.delete();
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                exp_q = e.data;
                if (e.host) exp_hv = 1'b1;
                else exp_cv = 1'b1;
            end
            check({tbl[k].name, ".cpu_valid"}, 32'(cvalid), 32'(exp_cv));
            check({tbl[k].name, ".host_valid"}, 32'(hvalid), 32'(exp_hv));
            if (exp_cv) check({tbl[k].name, ".cpu_q"}, cq, exp_q);
            if (exp_hv) check({tbl[k].name, ".host_q"}, hq, exp_q);

            exp_wren = (tbl[k].ecg & tbl[k].cwe) | (tbl[k].ehg & tbl[k].hwe);
            check({tbl[k].name, ".cpu_gnt"}, 32'(cgnt), 32'(tbl[k].ecg));
            check({tbl[k].name, ".host_gnt"}, 32'(hgnt), 32'(tbl[k].ehg));
            check({tbl[k].name, ".mem_wren"}, 32'(mem_wren), 32'(exp_wren));
            if (tbl[k].ecg || tbl[k].ehg) begin
                exp_addr = {19'd0, (tbl[k].ehg ? tbl[k].haddr[12:0] : tbl[k].caddr[12:0])};
                check({tbl[k].name, ".mem_addr"}, 32'(mem_addr), exp_addr);
            end
            if (exp_wren)
                check({tbl[k].name, ".mem_data"}, mem_data,
                      tbl[k].ehg ? tbl[k].hdata : tbl[k].cdata);

            if (tbl[k].ecg) begin
                if (tbl[k].cwe) shadow[tbl[k].caddr[12:0]] = tbl[k].cdata;
                else sb.push_back('{1'b0, shadow[tbl[k].caddr[12:0]]});
            end
            if (tbl[k].ehg) begin
                if (tbl[k].hwe) shadow[tbl[k].haddr[12:0]] = tbl[k].hdata;
                else sb.push_back('{1'b1, shadow[tbl[k].haddr[12:0]]});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
